// File: rtl/instmem_seq_loader.sv
// Byte-addressed little-endian instruction memory with a boot-load phase and a
// pipelined fetch port (1 or 2 cycle latency, stall, misalignment flag).
module instmem_seq_loader #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned READ_LAT = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [31:0]       ld_data,
  input  logic              ld_done,
  output logic [ADDR_W-1:0] ld_cnt,
  output logic              running,
  input  logic              req,
  input  logic [31:0]       adr,
  input  logic              stall,
  output logic              ready,
  output logic [31:0]       d_out,
  output logic              valid,
  output logic              misalign
);

  localparam int unsigned Words = 1 << (ADDR_W - 2);
  localparam logic [ADDR_W-1:0] CntMax = ADDR_W'(Words);

  localparam logic [0:0] StLoad = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       mem_q [Words];

  logic              ld_wr;
  logic              accept;
  logic              f_mis;
  logic [31:0]       f_word;

  // Only aligned words are ever stored or read, so a word-wide array suffices.
  assign ld_wr = ~rst & ld_en & (state_q == StLoad);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StLoad) begin
      if (ld_en && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
      if (ld_done) begin
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_wr) begin
      mem_q[ld_adr[ADDR_W-1:2]] <= ld_data;
    end
  end

  assign ld_cnt  = cnt_q;
  assign running = (state_q == StRun);
  assign ready   = running & ~stall;
  assign accept  = req & ready;

  // Upper address bits alias; a misaligned fetch never touches the array.
  assign f_mis  = |adr[1:0];
  assign f_word = f_mis ? NOP_WORD : mem_q[adr[ADDR_W-1:2]];

  logic        s1_valid_q;
  logic        s1_mis_q;
  logic [31:0] s1_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mis_q   <= 1'b0;
      s1_data_q  <= '0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q <= f_word;
        s1_mis_q  <= f_mis;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic        s2_valid_q;
      logic        s2_mis_q;
      logic [31:0] s2_data_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_mis_q   <= 1'b0;
          s2_data_q  <= '0;
        end else if (!stall) begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            s2_data_q <= s1_data_q;
            s2_mis_q  <= s1_mis_q;
          end
        end
      end

      assign valid    = s2_valid_q;
      assign misalign = s2_mis_q;
      assign d_out    = s2_data_q;
    end else begin : g_lat1
      assign valid    = s1_valid_q;
      assign misalign = s1_mis_q;
      assign d_out    = s1_data_q;
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{adr[31:ADDR_W], ld_adr[1:0]};

endmodule

// File: tb/tb_instmem_seq_loader.sv
// Bench for instmem_seq_loader: one READ_LAT=1 and one READ_LAT=2 instance share
// stimulus and are compared against a byte-level reference model.
module tb_instmem_seq_loader;

  localparam int unsigned AW  = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, ld_en, ld_done, req, stall;
  logic [AW-1:0] ld_adr;
  logic [31:0]   ld_data, adr;

  logic [AW-1:0] ld_cnt1, ld_cnt2;
  logic          running1, running2, ready1, ready2;
  logic          valid1, valid2, misalign1, misalign2;
  logic [31:0]   d_out1, d_out2;

  always #5 clk = ~clk;

  instmem_seq_loader #(.ADDR_W(AW), .READ_LAT(1), .NOP_WORD(NOP)) u_dut1 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_adr(ld_adr), .ld_data(ld_data),
    .ld_done(ld_done), .ld_cnt(ld_cnt1), .running(running1), .req(req), .adr(adr),
    .stall(stall), .ready(ready1), .d_out(d_out1), .valid(valid1), .misalign(misalign1)
  );

  instmem_seq_loader #(.ADDR_W(AW), .READ_LAT(2), .NOP_WORD(NOP)) u_dut2 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_adr(ld_adr), .ld_data(ld_data),
    .ld_done(ld_done), .ld_cnt(ld_cnt2), .running(running2), .req(req), .adr(adr),
    .stall(stall), .ready(ready2), .d_out(d_out2), .valid(valid2), .misalign(misalign2)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte memory, load state, and results delayed by L
  // non-stalled cycles.
  typedef struct {
    bit          v;
    bit          mis;
    logic [31:0] d;
  } res_t;

  logic [7:0]  mm [65536];
  bit          m_run = 1'b0;
  int          m_cnt = 0;
  res_t        hist[$];
  bit          m_v   [2];
  bit          m_mis [2];
  logic [31:0] m_d   [2];

  bit          e_stall;
  bit          collect = 1'b0;
  logic [31:0] got_q[$];

  function automatic logic [31:0] rd_word(input logic [15:0] a);
    return {mm[16'(a + 16'd3)], mm[16'(a + 16'd2)], mm[16'(a + 16'd1)], mm[a]};
  endfunction

  task automatic model_edge();
    bit   acc;
    res_t e;
    logic [15:0] wa;
    if (rst) begin
      m_run = 1'b0;
      m_cnt = 0;
      hist.delete();
      for (int l = 0; l < 2; l++) begin
        m_v[l] = 1'b0; m_mis[l] = 1'b0; m_d[l] = '0;
      end
      return;
    end
    acc = req && m_run && !stall;
    if (!m_run) begin
      if (ld_en) begin
        wa = {ld_adr[15:2], 2'b00};
        for (int b = 0; b < 4; b++) mm[16'(wa + 16'(b))] = ld_data[8*b +: 8];
        if (m_cnt < 16384) m_cnt++;
      end
      if (ld_done) m_run = 1'b1;
    end
    if (!stall) begin
      e.v   = acc;
      e.mis = acc && (adr[1:0] != 2'b00);
      e.d   = !acc ? 32'h0 : (e.mis ? NOP : rd_word(adr[15:0]));
      hist.push_front(e);
      if (hist.size() > 2) void'(hist.pop_back());
      for (int l = 0; l < 2; l++) begin
        if (hist.size() > l) begin
          m_v[l] = hist[l].v;
          if (hist[l].v) begin
            m_d[l]   = hist[l].d;
            m_mis[l] = hist[l].mis;
          end
        end else begin
          m_v[l] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) begin
      check_eq("ready1", 32'(ready1), 32'(m_run && !stall));
      check_eq("ready2", 32'(ready2), 32'(m_run && !stall));
    end
    @(posedge clk);
    e_stall = stall;
    model_edge();
    #1;
    check_eq("running1", 32'(running1), 32'(m_run));
    check_eq("running2", 32'(running2), 32'(m_run));
    check_eq("ld_cnt1", 32'(ld_cnt1), 32'(m_cnt));
    check_eq("ld_cnt2", 32'(ld_cnt2), 32'(m_cnt));
    check_eq("valid1", 32'(valid1), 32'(m_v[0]));
    check_eq("valid2", 32'(valid2), 32'(m_v[1]));
    check_eq("d_out1", d_out1, m_d[0]);
    check_eq("d_out2", d_out2, m_d[1]);
    if (m_v[0]) check_eq("misalign1", 32'(misalign1), 32'(m_mis[0]));
    if (m_v[1]) check_eq("misalign2", 32'(misalign2), 32'(m_mis[1]));
    if (collect && !e_stall && valid2) got_q.push_back(d_out2);
  endtask

  task automatic load(input logic [15:0] a, input logic [31:0] d, input bit done);
    ld_en = 1'b1; ld_adr = a; ld_data = d; ld_done = done;
    step();
    ld_en = 1'b0; ld_done = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    req = 1'b1; adr = a;
    step();
    req = 1'b0;
  endtask

  initial begin
    logic [31:0] exp4 [3];
    logic [13:0] widx;
    rst = 1'b1; ld_en = 1'b0; ld_done = 1'b0; req = 1'b0; stall = 1'b0;
    ld_adr = '0; ld_data = '0; adr = '0;
    step(); step();
    rst = 1'b0;
    check_eq("rst_valid1", 32'(valid1), 32'd0);
    check_eq("rst_dout2", d_out2, 32'd0);
    check_eq("rst_cnt", 32'(ld_cnt1), 32'd0);

    // Loads with a fetch request held high throughout; nothing may be accepted.
    req = 1'b1; adr = 32'h0;
    load(16'h0000, 32'h2401_0010, 1'b0);
    load(16'h0005, 32'h1820_0000, 1'b0);
    load(16'h0010, 32'h2402_0007, 1'b0);
    check_eq("t1_cnt3", 32'(ld_cnt1), 32'd3);
    check_eq("t2_load_valid", 32'(valid1), 32'd0);
    load(16'hFFFE, 32'hCAFE_F00D, 1'b1);
    check_eq("t2_cnt4", 32'(ld_cnt1), 32'd4);
    check_eq("t2_running", 32'(running1), 32'd1);
    req = 1'b0;

    fetch(32'h4);
    check_eq("t1_word1", d_out1, 32'h1820_0000);
    check_eq("t1_valid1", 32'(valid1), 32'd1);
    step();
    check_eq("t1_word2", d_out2, 32'h1820_0000);

    fetch(32'h6);
    check_eq("t3_mis_flag", 32'(misalign1), 32'd1);
    check_eq("t3_mis_word", d_out1, NOP);
    step();
    fetch(32'h0001_0010);
    check_eq("t3_alias", d_out1, 32'h2402_0007);
    step();
    fetch(32'h1234_FFFC);
    check_eq("t3_top_word", d_out1, 32'hCAFE_F00D);
    step();

    // Loader strobes after RUN must not touch memory.
    load(16'h0000, 32'hFFFF_FFFF, 1'b1);
    fetch(32'h0);
    check_eq("run_ld_ignored", d_out1, 32'h2401_0010);
    step();

    // Stall in the middle of a back-to-back stream.
    got_q.delete(); collect = 1'b1;
    req = 1'b1; adr = 32'h0; step();
    adr = 32'h4; step();
    stall = 1'b1; adr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t4_stall_ready", 32'(ready2), 32'd0);
    end
    stall = 1'b0; step();
    req = 1'b0; step(); step();
    collect = 1'b0;
    exp4[0] = 32'h2401_0010; exp4[1] = 32'h1820_0000; exp4[2] = 32'h2402_0007;
    check_eq("t4_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) check_eq("t4_order", got_q[i], exp4[i]);

    // Reset with fetches in flight.
    req = 1'b1; adr = 32'h0; step();
    adr = 32'h4; step();
    req = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    check_eq("t5_valid2", 32'(valid2), 32'd0);
    check_eq("t5_running", 32'(running1), 32'd0);
    check_eq("t5_cnt", 32'(ld_cnt2), 32'd0);
    ld_done = 1'b1; step(); ld_done = 1'b0;
    fetch(32'h0);
    check_eq("t5_mem_kept1", d_out1, 32'h2401_0010);
    step();
    check_eq("t5_mem_kept2", d_out2, 32'h2401_0010);

    // Fill all of memory (plus extra writes to hit the counter ceiling).
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 16387; i++) begin
      widx = 14'(i);
      ld_en = 1'b1; ld_adr = {widx, 2'($urandom)}; ld_data = $urandom;
      req = $urandom_range(1); adr = $urandom; stall = ($urandom_range(3) == 0);
      step();
    end
    ld_en = 1'b0; req = 1'b0; stall = 1'b0;
    check_eq("cnt_saturated", 32'(ld_cnt1), 32'd16384);
    ld_done = 1'b1; step(); ld_done = 1'b0;

    // Fully random traffic, including loader noise and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      req = ($urandom_range(3) != 0);
      adr = $urandom;
      if ($urandom_range(3) != 0) adr[1:0] = 2'b00;
      stall   = ($urandom_range(4) == 0);
      ld_en   = $urandom_range(1);
      ld_adr  = AW'($urandom);
      ld_data = $urandom;
      ld_done = ($urandom_range(7) == 0);
      rst     = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0; ld_en = 1'b0; ld_done = 1'b0; req = 1'b0; stall = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
